// File: rtl/vdf_sqr_seq_pkg.sv
// vdf_sqr_seq_pkg: shared FSM encoding and BLS12-381 field defaults
package vdf_sqr_seq_pkg;
    localparam int BITS_DEF = 382;
    localparam logic [BITS_DEF-1:0] MODULUS_DEF =
        382'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
    localparam int ITER_W_DEF = 32;
    localparam int MAX_SUB_DEF = 8;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, REDUCE, DONE} state_t;
endpackage

// File: rtl/vdf_sqr_seq_if.sv
// vdf_sqr_seq_if: job, result and multiplier handshakes of the squaring sequencer
interface vdf_sqr_seq_if
    import vdf_sqr_seq_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter int ITER_W = ITER_W_DEF
) ();
    logic              i_val;
    logic              o_rdy;
    logic [BITS-1:0]   i_dat;
    logic [ITER_W-1:0] i_iter;
    logic              o_val;
    logic              i_rdy;
    logic [BITS-1:0]   o_dat;
    logic              o_err;
    logic              o_mul_val;
    logic              i_mul_rdy;
    logic [BITS-1:0]   o_mul_dat_a;
    logic [BITS-1:0]   o_mul_dat_b;
    logic              i_mul_val;
    logic              o_mul_rdy;
    logic [BITS-1:0]   i_mul_dat;

    modport slave (
        input  i_val, i_dat, i_iter, i_rdy, i_mul_rdy, i_mul_val, i_mul_dat,
        output o_rdy, o_val, o_dat, o_err, o_mul_val, o_mul_dat_a, o_mul_dat_b, o_mul_rdy
    );

    modport master (
        output i_val, i_dat, i_iter, i_rdy, i_mul_rdy, i_mul_val, i_mul_dat,
        input  o_rdy, o_val, o_dat, o_err, o_mul_val, o_mul_dat_a, o_mul_dat_b, o_mul_rdy
    );
endinterface

// File: rtl/vdf_sqr_seq.sv
// vdf_sqr_seq: drives a modular multiplier through T dependent squarings, then fully reduces
module vdf_sqr_seq
    import vdf_sqr_seq_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter logic [BITS-1:0] MODULUS = BITS'(MODULUS_DEF),
    parameter int ITER_W = ITER_W_DEF,
    parameter int MAX_SUB = MAX_SUB_DEF
) (
    input logic        i_clk,
    input logic        i_rst,
    vdf_sqr_seq_if.slave bus
);
    localparam int SUB_W = $clog2(MAX_SUB + 1);

    state_t            state_q, state_d;
    logic [BITS-1:0]   x_q, x_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic              err_q, err_d;
    logic              ge;
    logic [BITS-1:0]   x_red;

    function automatic logic [BITS:0] cond_sub(input logic [BITS-1:0] v);
        return (v >= MODULUS) ? {1'b1, v - MODULUS} : {1'b0, v};
    endfunction

    assign {ge, x_red}     = cond_sub(x_q);
    assign bus.o_dat       = x_q;
    assign bus.o_mul_dat_a = x_q;
    assign bus.o_mul_dat_b = x_q;
    assign bus.o_err       = err_q;

    // Next-state and handshake outputs; the working value lives in x_q throughout
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        cnt_d         = cnt_q;
        sub_d         = sub_q;
        err_d         = err_q;
        bus.o_rdy     = 1'b0;
        bus.o_val     = 1'b0;
        bus.o_mul_val = 1'b0;
        bus.o_mul_rdy = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.o_rdy = !i_rst;
                if (bus.i_val) begin
                    x_d     = bus.i_dat;
                    cnt_d   = bus.i_iter;
                    sub_d   = '0;
                    err_d   = 1'b0;
                    state_d = (bus.i_iter != '0) ? ISSUE : REDUCE;
                end
            end
            ISSUE: begin
                bus.o_mul_val = 1'b1;
                if (bus.i_mul_rdy) begin
                    cnt_d   = cnt_q - ITER_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                bus.o_mul_rdy = 1'b1;
                if (bus.i_mul_val) begin
                    x_d     = bus.i_mul_dat;
                    state_d = (cnt_q == '0) ? REDUCE : ISSUE;
                end
            end
            REDUCE: begin
                if (!ge) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (sub_q == SUB_W'(MAX_SUB)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    x_d   = x_red;
                    sub_d = sub_q + SUB_W'(1);
                end
            end
            DONE: begin
                bus.o_val = 1'b1;
                if (bus.i_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any job in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            sub_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            err_q   <= err_d;
        end
    end

    // A multiplier result is only legal while a squaring is outstanding
    always_ff @(posedge i_clk) begin
        if (!i_rst) assert (!bus.i_mul_val || state_q == WAIT);
    end
endmodule

// File: tb/tb_vdf_sqr_seq.sv
// tb_vdf_sqr_seq: randomized self-checking bench with multiplier stub and modular-power model
module tb_vdf_sqr_seq;
    import vdf_sqr_seq_pkg::*;

    typedef logic [383:0] w_t;
    localparam logic [381:0] P  = MODULUS_DEF;
    localparam logic [763:0] P2 = {382'b0, MODULUS_DEF};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nerr = 0;
    int   viol = 0;
    int   issues = 0;
    int   mlat = 0;
    logic mbusy = 1'b0, op_taken = 1'b0, res_taken = 1'b0;
    logic hold_m = 1'b0, hold_o = 1'b0, prev_e = 1'b0;
    logic [381:0] op_a, prev_a, prev_d;
    logic [763:0] prod;

    vdf_sqr_seq_if #(.BITS(382), .ITER_W(32)) sq ();
    vdf_sqr_seq_if #(.BITS(16), .ITER_W(32)) sm ();

    vdf_sqr_seq u_dut (.i_clk(clk), .i_rst(rst), .bus(sq.slave));
    vdf_sqr_seq #(.BITS(16), .MODULUS(16'd1000), .ITER_W(32), .MAX_SUB(8))
        u_small (.i_clk(clk), .i_rst(rst), .bus(sm.slave));

    always #5 clk = ~clk;

    function automatic logic [381:0] model(input logic [381:0] x, input int t);
        logic [763:0] v;
        v = {382'b0, x} % P2;
        for (int i = 0; i < t; i++) v = (v * v) % P2;
        return v[381:0];
    endfunction

    function automatic logic [381:0] rnd_x();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
        return v[381:0];
    endfunction

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Multiplier stub (partially reduced result, random latency and stalls) plus stability monitor
    always @(negedge clk) begin
        if (rst) begin
            sq.i_mul_val = 1'b0;
            sq.i_mul_rdy = 1'b0;
            sq.i_mul_dat = '0;
            mbusy = 1'b0; op_taken = 1'b0; res_taken = 1'b0; hold_m = 1'b0; hold_o = 1'b0;
        end else begin
            if (hold_m && (!sq.o_mul_val || sq.o_mul_dat_a !== prev_a)) viol++;
            if (sq.o_mul_val && sq.o_mul_dat_b !== sq.o_mul_dat_a) viol++;
            if (hold_o && (!sq.o_val || sq.o_dat !== prev_d || sq.o_err !== prev_e)) viol++;
            if (res_taken) begin
                sq.i_mul_val = 1'b0;
                mbusy = 1'b0;
            end
            if (op_taken) begin
                issues++;
                mbusy = 1'b1;
                mlat = $urandom_range(0, 3);
                prod = ({382'b0, op_a} * {382'b0, op_a}) % P2;
                sq.i_mul_dat = prod[381:0] + (($urandom_range(0, 1) == 1) ? P : 382'd0);
            end
            if (mbusy && !sq.i_mul_val) begin
                if (mlat == 0) sq.i_mul_val = 1'b1;
                else mlat--;
            end
            sq.i_mul_rdy = !mbusy && ($urandom_range(0, 3) != 0);
            op_taken  = sq.o_mul_val && sq.i_mul_rdy;
            op_a      = sq.o_mul_dat_a;
            res_taken = sq.i_mul_val && sq.o_mul_rdy;
            hold_m    = sq.o_mul_val && !sq.i_mul_rdy;
            prev_a    = sq.o_mul_dat_a;
            hold_o    = sq.o_val && !sq.i_rdy;
            prev_d    = sq.o_dat;
            prev_e    = sq.o_err;
        end
    end

    task automatic send(input logic [381:0] x, input logic [31:0] t);
        int n;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        sq.i_dat = x; sq.i_iter = t; sq.i_val = 1'b1;
        n = 0;
        while (!sq.o_rdy && n < 100) begin @(posedge clk); #1; n++; end
        chk("accept_ready", w_t'(sq.o_rdy), w_t'(1));
        @(posedge clk); #1;
        sq.i_val = 1'b0;
    endtask

    task automatic recv(output logic [381:0] d, output logic e, output int lat);
        lat = 0;
        while (!sq.o_val && lat < 3000) begin @(posedge clk); #1; lat++; end
        chk("result_valid", w_t'(sq.o_val), w_t'(1));
        d = sq.o_dat; e = sq.o_err;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        sq.i_rdy = 1'b1;
        @(posedge clk); #1;
        sq.i_rdy = 1'b0;
    endtask

    task automatic job(input string tag, input logic [381:0] x, input int t, input int exp_lat);
        logic [381:0] d;
        logic e;
        int lat, i0;
        i0 = issues;
        send(x, 32'(t));
        recv(d, e, lat);
        chk({tag, "_dat"}, w_t'(d), w_t'(model(x, t)));
        chk({tag, "_err"}, w_t'(e), w_t'(0));
        chk({tag, "_issues"}, w_t'(issues - i0), w_t'(t));
        if (exp_lat >= 0) chk({tag, "_reduce_cycles"}, w_t'(lat), w_t'(exp_lat));
    endtask

    task automatic sm_job(input string tag, input logic [15:0] x, input int t, input logic [15:0] mres,
                          input logic [15:0] exp_d, input logic exp_e, input int exp_lat);
        int lat;
        chk({tag, "_ready"}, w_t'(sm.o_rdy), w_t'(1));
        sm.i_dat = x; sm.i_iter = 32'(t); sm.i_val = 1'b1;
        @(posedge clk); #1;
        sm.i_val = 1'b0;
        if (t != 0) begin
            sm.i_mul_rdy = 1'b1;
            @(posedge clk); #1;
            sm.i_mul_rdy = 1'b0; sm.i_mul_val = 1'b1; sm.i_mul_dat = mres;
            @(posedge clk); #1;
            sm.i_mul_val = 1'b0;
        end
        lat = 0;
        while (!sm.o_val && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, "_dat"}, w_t'(sm.o_dat), w_t'(exp_d));
        chk({tag, "_err"}, w_t'(sm.o_err), w_t'(exp_e));
        chk({tag, "_reduce_cycles"}, w_t'(lat), w_t'(exp_lat));
        sm.i_rdy = 1'b1;
        @(posedge clk); #1;
        sm.i_rdy = 1'b0;
    endtask

    initial begin
        logic [381:0] d;
        logic e;
        int lat, n, i0;
        sq.i_val = 1'b0; sq.i_rdy = 1'b0; sq.i_dat = '0; sq.i_iter = '0;
        sm.i_val = 1'b0; sm.i_rdy = 1'b0; sm.i_dat = '0; sm.i_iter = '0;
        sm.i_mul_rdy = 1'b0; sm.i_mul_val = 1'b0; sm.i_mul_dat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_rdy", w_t'(sq.o_rdy), w_t'(0));
        chk("rst_o_val", w_t'(sq.o_val), w_t'(0));
        chk("rst_o_err", w_t'(sq.o_err), w_t'(0));
        chk("rst_o_mul_val", w_t'(sq.o_mul_val), w_t'(0));
        chk("rst_o_mul_rdy", w_t'(sq.o_mul_rdy), w_t'(0));
        chk("rst_o_dat", w_t'(sq.o_dat), w_t'(0));
        chk("rst_o_mul_dat_a", w_t'(sq.o_mul_dat_a), w_t'(0));
        chk("rst_o_mul_dat_b", w_t'(sq.o_mul_dat_b), w_t'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_o_rdy", w_t'(sq.o_rdy), w_t'(1));
        @(posedge clk); #1;

        job("x5_t0", 382'd5, 0, 1);
        job("p_plus3_t0", P + 382'd3, 0, 2);
        job("p_t0", P, 0, 2);
        job("p_minus1_t0", P - 382'd1, 0, 1);
        job("2p_plus1_t0", P + P + 382'd1, 0, 3);
        job("x2_t1", 382'd2, 1, -1);
        job("x3_t10", 382'd3, 10, -1);
        for (int k = 0; k < 6; k++) job("rand", rnd_x(), int'($urandom_range(1, 20)), -1);

        sm_job("err_20m1", 16'd7, 1, 16'd20001, 16'd12001, 1'b1, 9);
        sm_job("maxsub_8m5", 16'd8005, 0, 16'd0, 16'd5, 1'b0, 9);

        i0 = issues;
        send(rnd_x(), 32'd100);
        n = 0;
        while (!(mbusy && issues - i0 >= 3) && n < 500) begin @(posedge clk); #1; n++; end
        chk("reach_wait", w_t'(mbusy), w_t'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_o_rdy_in_rst", w_t'(sq.o_rdy), w_t'(0));
        rst = 1'b0;
        #1;
        chk("midrst_o_rdy", w_t'(sq.o_rdy), w_t'(1));
        chk("midrst_o_val", w_t'(sq.o_val), w_t'(0));
        chk("midrst_o_mul_val", w_t'(sq.o_mul_val), w_t'(0));
        @(posedge clk); #1;
        job("after_rst_x2_t1", 382'd2, 1, -1);

        chk("handshake_stability", w_t'(viol), w_t'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
